// File: rtl/contatore_pkg.sv
// Shared definitions for the up/down modulo counter: count direction encoding
// and a constant clog2 helper used to size the prescaler register.
package contatore_pkg;

    typedef enum logic {
        DIR_DOWN = 1'b0,
        DIR_UP   = 1'b1
    } dir_e;

    // Ceiling log2 for elaboration-time sizing (returns 0 for value <= 1).
    function automatic int clog2_f(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/contatore_prescaler.sv
// Prescaler for the up/down counter: asserts tick on every PRESCALE-th enabled
// cycle. clr restarts the division from zero; en=0 freezes the count.
module contatore_prescaler
    import contatore_pkg::*;
#(
    parameter int PRESCALE = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int             L_PW   = (clog2_f(PRESCALE) < 1) ? 1 : clog2_f(PRESCALE);
    localparam logic [L_PW-1:0] L_LAST = L_PW'(PRESCALE - 1);
    localparam logic [L_PW-1:0] L_ZERO = {L_PW{1'b0}};
    localparam logic [L_PW-1:0] L_ONE  = L_PW'(1);

    logic [L_PW-1:0] r_cnt;

    // Tick on the enabled cycle that completes a division period.
    assign tick = en & (r_cnt == L_LAST);

    // Division counter: cleared by clr, advances only on enabled cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= L_ZERO;
        end else if (clr) begin
            r_cnt <= L_ZERO;
        end else if (en) begin
            if (r_cnt == L_LAST) begin
                r_cnt <= L_ZERO;
            end else begin
                r_cnt <= r_cnt + L_ONE;
            end
        end else begin
            r_cnt <= r_cnt;
        end
    end

endmodule

// File: rtl/contatore_updown_mod.sv
// Up/down modulo-MODULO counter with optional prescaler, parallel load,
// terminal-count output for cascading and a registered wrap pulse.
// Build option: define CONTATORE_SATURATE_EN to make the counter saturate at
// the range ends instead of wrapping (wrap then stays 0).
module contatore_updown_mod
    import contatore_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int MODULO   = 2 ** WIDTH,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic             up,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] y,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] L_MAX     = WIDTH'(MODULO - 1);
    localparam logic [WIDTH-1:0] L_ZERO    = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] L_ONE     = WIDTH'(1);
    localparam logic [WIDTH:0]   L_MOD_EXT = (WIDTH + 1)'(MODULO);

    logic [WIDTH-1:0] r_y;
    logic             r_wrap;
    logic [WIDTH-1:0] w_y_next;
    logic             w_wrap_next;
    logic             w_tick;
    logic             w_d_in_range;
    dir_e             w_dir;

    assign w_dir        = dir_e'(up);
    assign w_d_in_range = ({1'b0, d} < L_MOD_EXT);

    generate
        if (PRESCALE > 1) begin : g_prescale
            contatore_prescaler #(
                .PRESCALE (PRESCALE)
            ) u_prescaler (
                .clk  (clk),
                .rst  (rst),
                .en   (en),
                .clr  (load),
                .tick (w_tick)
            );
        end else begin : g_no_prescale
            assign w_tick = en;
        end
    endgenerate

    // Next count: load has priority, then a step on tick, otherwise hold.
    always_comb begin
        w_y_next    = r_y;
        w_wrap_next = 1'b0;
        if (load) begin
            if (w_d_in_range) begin
                w_y_next = d;
            end else begin
                w_y_next = L_MAX;
            end
        end else if (w_tick) begin
            case (w_dir)
                DIR_UP: begin
                    if (r_y == L_MAX) begin
`ifdef CONTATORE_SATURATE_EN
                        w_y_next = r_y;
`else
                        w_y_next    = L_ZERO;
                        w_wrap_next = 1'b1;
`endif
                    end else begin
                        w_y_next = r_y + L_ONE;
                    end
                end
                DIR_DOWN: begin
                    if (r_y == L_ZERO) begin
`ifdef CONTATORE_SATURATE_EN
                        w_y_next = r_y;
`else
                        w_y_next    = L_MAX;
                        w_wrap_next = 1'b1;
`endif
                    end else begin
                        w_y_next = r_y - L_ONE;
                    end
                end
                default: begin
                    w_y_next = r_y;
                end
            endcase
        end else begin
            w_y_next = r_y;
        end
    end

    // Count and wrap-pulse registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y    <= L_ZERO;
            r_wrap <= 1'b0;
        end else begin
            r_y    <= w_y_next;
            r_wrap <= w_wrap_next;
        end
    end

    assign y    = r_y;
    assign wrap = r_wrap;
    // Terminal count is combinational so a following stage can use tc & tick.
    assign tc   = en & ((w_dir == DIR_UP) ? (r_y == L_MAX) : (r_y == L_ZERO));

endmodule

// File: tb/tb_contatore_updown_mod.sv
// Self-checking bench for contatore_updown_mod: two instances (PRESCALE=1 and
// PRESCALE=3, WIDTH=4, MODULO=10) share stimulus and are checked every cycle
// against an arithmetic reference model, plus directed literal scenarios.
module tb_contatore_updown_mod;

    localparam int MOD = 10;
`ifdef CONTATORE_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       load = 1'b0;
    logic       up = 1'b1;
    logic [3:0] d = 4'd0;
    logic [3:0] y1, y3;
    logic       tc1, tc3, wrap1, wrap3;

    int checks = 0;
    int failures = 0;
    bit run_cmp = 1'b0;

    int m_y[2]    = '{0, 0};
    int m_wrap[2] = '{0, 0};
    int m_seen[2] = '{0, 0};

    always #5 clk = ~clk;

    contatore_updown_mod #(.WIDTH(4), .MODULO(10), .PRESCALE(1)) u_dut1 (
        .clk(clk), .rst(rst), .en(en), .load(load), .up(up), .d(d),
        .y(y1), .tc(tc1), .wrap(wrap1)
    );

    contatore_updown_mod #(.WIDTH(4), .MODULO(10), .PRESCALE(3)) u_dut3 (
        .clk(clk), .rst(rst), .en(en), .load(load), .up(up), .d(d),
        .y(y3), .tc(tc3), .wrap(wrap3)
    );

    function automatic int ps_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: count enabled cycles, step every ps-th one, modular arithmetic.
    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_y[i] = 0; m_wrap[i] = 0; m_seen[i] = 0;
            end else if (load) begin
                m_y[i] = (int'(d) < MOD) ? int'(d) : MOD - 1;
                m_wrap[i] = 0; m_seen[i] = 0;
            end else if (en) begin
                int target;
                m_wrap[i] = 0;
                m_seen[i] = m_seen[i] + 1;
                if (m_seen[i] == ps_of(i)) begin
                    m_seen[i] = 0;
                    target = m_y[i] + (up ? 1 : -1);
                    if (target < 0 || target >= MOD) begin
                        if (!SAT) begin
                            m_y[i] = (target + MOD) % MOD;
                            m_wrap[i] = 1;
                        end
                    end else begin
                        m_y[i] = target;
                    end
                end
            end else begin
                m_wrap[i] = 0;
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (run_cmp) begin
            check("y_p1", int'(y1), m_y[0]);
            check("wrap_p1", int'(wrap1), m_wrap[0]);
            check("tc_p1", int'(tc1), (en && (up ? m_y[0] == MOD-1 : m_y[0] == 0)) ? 1 : 0);
            check("y_p3", int'(y3), m_y[1]);
            check("wrap_p3", int'(wrap3), m_wrap[1]);
            check("tc_p3", int'(tc3), (en && (up ? m_y[1] == MOD-1 : m_y[1] == 0)) ? 1 : 0);
        end
    end

    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp31[12];
        int exp32[11];
        int exp33[11];
        int r;

        if (SAT) begin
            exp31 = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 9, 9, 9};
            exp32 = '{8, 7, 6, 5, 4, 3, 2, 1, 0, 0, 0};
        end else begin
            exp31 = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
            exp32 = '{8, 7, 6, 5, 4, 3, 2, 1, 0, 9, 8};
        end
        exp33 = '{0, 0, 1, 1, 1, 1, 1, 2, 2, 2, 3};

        // Reset state
        repeat (2) step_clk();
        check("reset_y1", int'(y1), 0);
        check("reset_wrap1", int'(wrap1), 0);
        check("reset_y3", int'(y3), 0);
        rst = 1'b0;
        run_cmp = 1'b1;

        // Count up 12 cycles across the 9 -> 0 boundary
        en = 1'b1; up = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i == 8) begin
                // y is about to read 8 -> check tc at y=9 after this edge
            end
            step_clk();
            check("up_seq_y", int'(y1), exp31[i]);
            check("up_seq_wrap", int'(wrap1), (!SAT && i == 9) ? 1 : 0);
            check("up_seq_tc", int'(tc1), (exp31[i] == 9) ? 1 : 0);
        end

        // Load beats a simultaneous wrapping step
        en = 1'b0; load = 1'b1; d = 4'd9;
        step_clk();
        en = 1'b1; up = 1'b1; d = 4'd2;
        step_clk();
        check("load_prio_y", int'(y1), 2);
        check("load_prio_wrap", int'(wrap1), 0);
        check("load_prio_y3", int'(y3), 2);

        // Out-of-range load clamps, then count down through 0 -> 9
        en = 1'b0; d = 4'd13;
        step_clk();
        check("load_clamp", int'(y1), 9);
        load = 1'b0; up = 1'b0; en = 1'b1;
        for (int i = 0; i < 11; i++) begin
            step_clk();
            check("down_seq_y", int'(y1), exp32[i]);
            check("down_seq_wrap", int'(wrap1), (!SAT && i == 9) ? 1 : 0);
        end

        // Asynchronous reset between edges while counting at 5
        load = 1'b1; en = 1'b0; d = 4'd4;
        step_clk();
        load = 1'b0; en = 1'b1; up = 1'b1;
        step_clk();
        check("pre_rst_y", int'(y1), 5);
        #2;
        rst = 1'b1; load = 1'b1; d = 4'd7;
        #1;
        check("async_rst_y1", int'(y1), 0);
        check("async_rst_wrap1", int'(wrap1), 0);
        check("async_rst_y3", int'(y3), 0);
        step_clk();
        check("rst_hold_y1", int'(y1), 0);
        rst = 1'b0; load = 1'b0; en = 1'b1; up = 1'b1;

        // Prescaled counting with en dropped for two cycles
        for (int k = 1; k <= 11; k++) begin
            en = (k == 4 || k == 5) ? 1'b0 : 1'b1;
            step_clk();
            check("prescale_y3", int'(y3), exp33[k-1]);
        end

        // Randomized phase
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 63);
            rst  = (r == 0);
            load = (r >= 1 && r <= 4);
            en   = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) up = ~up;
            d = 4'($urandom_range(0, 15));
            step_clk();
        end
        rst = 1'b0;
        step_clk();

        run_cmp = 1'b0;
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
